// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one single-port memory between fetch and data ports
// Reads hold the port for MEM_LAT cycles; writes complete in the grant cycle.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_LAT    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy
);

    typedef enum logic {IDLE, WAIT} state_t;

    localparam logic [2:0] LAT = 3'(MEM_LAT);

    state_t     state, state_nxt;
    logic [2:0] cnt, cnt_nxt;
    logic       owner, owner_nxt;       // 0 = fetch, 1 = data
    logic       last_gnt, last_gnt_nxt; // 0 = fetch, 1 = data

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= 3'd0;
            owner    <= 1'b0;
            last_gnt <= 1'b1;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            owner    <= owner_nxt;
            last_gnt <= last_gnt_nxt;
        end
    end

    // Outputs are forced low while reset is held, even with requests pending.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        owner_nxt    = owner;
        last_gnt_nxt = last_gnt;
        if_gnt       = 1'b0;
        if_rvalid    = 1'b0;
        if_rdata     = '0;
        d_gnt        = 1'b0;
        d_rvalid     = 1'b0;
        d_rdata      = '0;
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        busy         = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (if_req && (!d_req || last_gnt)) begin
                        if_gnt       = 1'b1;
                        mem_en       = 1'b1;
                        mem_addr     = if_addr;
                        last_gnt_nxt = 1'b0;
                        owner_nxt    = 1'b0;
                        state_nxt    = WAIT;
                        cnt_nxt      = LAT;
                    end else if (d_req) begin
                        d_gnt        = 1'b1;
                        mem_en       = 1'b1;
                        mem_we       = d_we;
                        mem_addr     = d_addr;
                        mem_wdata    = d_wdata;
                        last_gnt_nxt = 1'b1;
                        if (!d_we) begin
                            owner_nxt = 1'b1;
                            state_nxt = WAIT;
                            cnt_nxt   = LAT;
                        end
                    end
                end
                WAIT: begin
                    busy    = 1'b1;
                    cnt_nxt = cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        state_nxt = IDLE;
                        if (owner) begin
                            d_rvalid = 1'b1;
                            d_rdata  = mem_rdata;
                        end else begin
                            if_rvalid = 1'b1;
                            if_rdata  = mem_rdata;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter at MEM_LAT 1, 2 and 3
module tb_mem_arbiter;

    localparam int OW = 113;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [9:0]  if_addr = '0;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [9:0]  d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] mem_rdata = '0;

    logic        if_gnt_v [3];
    logic        if_rvalid_v [3];
    logic [31:0] if_rdata_v [3];
    logic        d_gnt_v [3];
    logic        d_rvalid_v [3];
    logic [31:0] d_rdata_v [3];
    logic        mem_en_v [3];
    logic        mem_we_v [3];
    logic [9:0]  mem_addr_v [3];
    logic [31:0] mem_wdata_v [3];
    logic        busy_v [3];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mem_arbiter #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .MEM_LAT(g + 1)) u_dut (
            .clk       (clk),
            .reset     (reset),
            .if_req    (if_req),
            .if_addr   (if_addr),
            .if_gnt    (if_gnt_v[g]),
            .if_rvalid (if_rvalid_v[g]),
            .if_rdata  (if_rdata_v[g]),
            .d_req     (d_req),
            .d_we      (d_we),
            .d_addr    (d_addr),
            .d_wdata   (d_wdata),
            .d_gnt     (d_gnt_v[g]),
            .d_rvalid  (d_rvalid_v[g]),
            .d_rdata   (d_rdata_v[g]),
            .mem_en    (mem_en_v[g]),
            .mem_we    (mem_we_v[g]),
            .mem_addr  (mem_addr_v[g]),
            .mem_wdata (mem_wdata_v[g]),
            .mem_rdata (mem_rdata),
            .busy      (busy_v[g])
        );
    end

    function automatic logic [OW-1:0] pk(logic ig, logic iv, logic [31:0] ird, logic dg, logic dv,
                                         logic [31:0] drd, logic en, logic we, logic [9:0] ad,
                                         logic [31:0] wd, logic bz);
        return {ig, iv, ird, dg, dv, drd, en, we, ad, wd, bz};
    endfunction

    function automatic logic [OW-1:0] obs(int k);
        return pk(if_gnt_v[k], if_rvalid_v[k], if_rdata_v[k], d_gnt_v[k], d_rvalid_v[k], d_rdata_v[k],
                  mem_en_v[k], mem_we_v[k], mem_addr_v[k], mem_wdata_v[k], busy_v[k]);
    endfunction

    task automatic chk(string nm, logic [OW-1:0] got, logic [OW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic chk1(string nm, logic got, logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b exp=%b", nm, got, exp);
        end
    endtask

    task automatic drv(bit r, bit ir, logic [9:0] ia, bit dr, bit dw, logic [9:0] da,
                       logic [31:0] wd, logic [31:0] rd);
        @(posedge clk);
        #1;
        reset = r; if_req = ir; if_addr = ia; d_req = dr; d_we = dw;
        d_addr = da; d_wdata = wd; mem_rdata = rd;
    endtask

    // Reference model: a read granted at cycle g owns the port through cycle g+L and
    // delivers data in cycle g+L; the port is free whenever the current cycle is past that.
    int cyc = 0;
    int due [3] = '{-10, -10, -10};
    bit own [3];
    bit last [3] = '{1'b1, 1'b1, 1'b1};

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            logic ig, iv, dg, dv, en, we, bz, fw, dwin;
            logic [31:0] ird, drd, wd;
            logic [9:0] ad;
            ig = 0; iv = 0; dg = 0; dv = 0; en = 0; we = 0; bz = 0;
            ird = 0; drd = 0; wd = 0; ad = 0;
            if (reset) begin
                due[k] = -10; own[k] = 0; last[k] = 1;
            end else if (cyc <= due[k]) begin
                bz = 1;
                if (cyc == due[k]) begin
                    if (own[k]) begin dv = 1; drd = mem_rdata; end
                    else begin iv = 1; ird = mem_rdata; end
                end
            end else begin
                fw   = if_req && (!d_req || last[k]);
                dwin = d_req && !fw;
                if (fw) begin ig = 1; en = 1; ad = if_addr; end
                if (dwin) begin dg = 1; en = 1; we = d_we; ad = d_addr; wd = d_wdata; end
                if (fw || dwin) last[k] = dwin;
                if (fw || (dwin && !d_we)) begin
                    due[k] = cyc + k + 1;
                    own[k] = dwin;
                end
            end
            chk($sformatf("model_lat%0d_cyc%0d", k + 1, cyc), obs(k),
                pk(ig, iv, ird, dg, dv, drd, en, we, ad, wd, bz));
        end
        cyc++;
    end

    typedef struct {
        bit          r, ir, dr, dw;
        logic [9:0]  ia, da;
        logic [31:0] wd, rd;
        logic [OW-1:0] exp;
    } vec_t;

    vec_t tbl [13];

    initial begin
        // Rows run on the MEM_LAT=1 instance, one per cycle.
        tbl[0]  = '{1,1,0,0, 10'h004, 10'h000, 0, 0, '0};
        tbl[1]  = '{0,1,0,0, 10'h004, 10'h000, 0, 32'hDEAD0001,
                    pk(1,0,0, 0,0,0, 1,0,10'h004,0, 0)};
        tbl[2]  = '{0,0,0,0, 10'h000, 10'h000, 0, 32'h00500093,
                    pk(0,1,32'h00500093, 0,0,0, 0,0,0,0, 1)};
        tbl[3]  = '{0,0,0,0, 10'h000, 10'h000, 0, 32'h12345678, '0};
        tbl[4]  = '{1,1,1,0, 10'h008, 10'h100, 0, 0, '0};
        tbl[5]  = '{0,1,1,0, 10'h008, 10'h100, 0, 0,
                    pk(1,0,0, 0,0,0, 1,0,10'h008,0, 0)};
        tbl[6]  = '{0,0,1,0, 10'h000, 10'h100, 0, 32'h11111111,
                    pk(0,1,32'h11111111, 0,0,0, 0,0,0,0, 1)};
        tbl[7]  = '{0,0,1,0, 10'h000, 10'h100, 0, 0,
                    pk(0,0,0, 1,0,0, 1,0,10'h100,0, 0)};
        tbl[8]  = '{0,0,0,0, 10'h000, 10'h000, 0, 32'h22222222,
                    pk(0,0,0, 0,1,32'h22222222, 0,0,0,0, 1)};
        tbl[9]  = '{0,0,1,1, 10'h000, 10'h010, 32'hA, 32'h55,
                    pk(0,0,0, 1,0,0, 1,1,10'h010,32'hA, 0)};
        tbl[10] = '{0,0,1,1, 10'h000, 10'h011, 32'hB, 32'h55,
                    pk(0,0,0, 1,0,0, 1,1,10'h011,32'hB, 0)};
        tbl[11] = '{0,0,1,1, 10'h000, 10'h012, 32'hC, 32'h55,
                    pk(0,0,0, 1,0,0, 1,1,10'h012,32'hC, 0)};
        tbl[12] = '{0,0,0,0, 10'h000, 10'h000, 0, 32'hFFFFFFFF, '0};

        for (int i = 0; i < 13; i++) begin
            drv(tbl[i].r, tbl[i].ir, tbl[i].ia, tbl[i].dr, tbl[i].dw, tbl[i].da, tbl[i].wd, tbl[i].rd);
            @(negedge clk);
            chk($sformatf("vec%0d", i), obs(0), tbl[i].exp);
        end

        // Continuous contention at MEM_LAT=2: grants alternate every 3 cycles, fetch first.
        drv(1, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 12; c++) begin
            drv(0, 1, 10'h040, 1, 0, 10'h080, 0, 32'(c));
            @(negedge clk);
            chk1($sformatf("rr_if_gnt_c%0d", c), if_gnt_v[1], (c % 3 == 0) && ((c / 3) % 2 == 0));
            chk1($sformatf("rr_d_gnt_c%0d", c), d_gnt_v[1], (c % 3 == 0) && ((c / 3) % 2 == 1));
        end

        // Reset mid-read at MEM_LAT=3.
        drv(1, 0, 0, 0, 0, 0, 0, 0);
        drv(0, 1, 10'h004, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk1("rst_mid_gnt0", if_gnt_v[2], 1'b1);
        drv(1, 1, 10'h004, 1, 0, 10'h009, 0, 32'h77);
        @(negedge clk);
        chk("rst_mid_outputs_zero", obs(2), '0);
        drv(0, 1, 10'h020, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk1("rst_release_gnt", if_gnt_v[2], 1'b1);
        for (int j = 0; j < 3; j++) begin
            drv(0, 0, 0, 0, 0, 0, 0, 32'h3300 + 32'(j));
            @(negedge clk);
            chk1($sformatf("rst_rvalid_j%0d", j), if_rvalid_v[2], j == 2);
        end

        // Data request appearing only during the fetch wait at MEM_LAT=2.
        drv(1, 0, 0, 0, 0, 0, 0, 0);
        drv(0, 1, 10'h00C, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk1("wait_req_if_gnt", if_gnt_v[1], 1'b1);
        for (int j = 0; j < 2; j++) begin
            drv(0, 0, 0, 1, 0, 10'h0AA, 0, 32'h4400);
            @(negedge clk);
            chk1($sformatf("wait_req_no_dgnt_j%0d", j), d_gnt_v[1], 1'b0);
            chk1($sformatf("wait_req_if_rvalid_j%0d", j), if_rvalid_v[1], j == 1);
        end
        drv(0, 0, 0, 1, 0, 10'h0AA, 0, 0);
        @(negedge clk);
        chk1("wait_req_dgnt_after", d_gnt_v[1], 1'b1);

        // Random traffic, all three instances checked by the model every cycle.
        for (int c = 0; c < 2000; c++) begin
            drv(($urandom_range(63) == 0), $urandom_range(1), 10'($urandom), $urandom_range(1),
                $urandom_range(1), 10'($urandom), $urandom, $urandom);
        end
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
